// File: rtl/slot_pkg.sv
// Shared types and constants for the twelve-slot occupancy tracker.
// Imported by dec12 and slot_map12.
package slot_pkg;

  localparam int SLOTS = 12;
  localparam int QDEPTH = 4;

  typedef logic [3:0] slot_idx_t;
  typedef logic [11:0] slot_map_t;
  typedef logic [1:0] qptr_t;
  typedef logic [2:0] qcnt_t;

  localparam slot_idx_t IDX_NONE = 4'd15;
  localparam slot_idx_t IDX_LAST = 4'd11;

endpackage

// File: rtl/slot_map12_dec12.sv
// Index to one-hot decoder for twelve slots.
// Ports: idx_i (4b) -> mask_o (12b one-hot), illegal_o (index 12..14).
module dec12
  import slot_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [11:0] mask_o,
  output logic        illegal_o
);

  always_comb begin
    mask_o    = '0;
    illegal_o = 1'b0;
    if (idx_i <= IDX_LAST) begin
      mask_o = slot_map_t'(1) << idx_i;
    end else if (idx_i != IDX_NONE) begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/slot_map12.sv
// Twelve-slot occupancy map with queued releases, count and sticky error.
// Ports: clk, rst_n (sync low), flush_i, set_v_i/set_idx_i,
// clr_v_i/clr_idx_i/clr_rdy_o, map_o, cnt_o, full_o, empty_o,
// err_o, err_clr_i.
module slot_map12
  import slot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        set_v_i,
  input  logic [3:0]  set_idx_i,
  input  logic        clr_v_i,
  input  logic [3:0]  clr_idx_i,
  output logic        clr_rdy_o,
  output logic [11:0] map_o,
  output logic [3:0]  cnt_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  slot_map_t map_q, map_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  slot_idx_t mem_q [QDEPTH];
  slot_idx_t mem_d [QDEPTH];
  qptr_t     wp_q, wp_d;
  qptr_t     rp_q, rp_d;
  qcnt_t     qc_q, qc_d;

  slot_map_t set_mask, drn_mask;
  logic      set_ill, drn_ill;

  logic      push, drain, ovf;
  slot_map_t map_clr;
  logic      drn_hit, drn_miss;
  logic      set_new, set_dup;
  logic      new_err;

  dec12 u_dec_set (
    .idx_i     (set_idx_i),
    .mask_o    (set_mask),
    .illegal_o (set_ill)
  );

  dec12 u_dec_drn (
    .idx_i     (mem_q[rp_q]),
    .mask_o    (drn_mask),
    .illegal_o (drn_ill)
  );

  assign clr_rdy_o = (qc_q < qcnt_t'(QDEPTH));

  always_comb begin
    push  = clr_v_i && clr_rdy_o;
    ovf   = clr_v_i && !clr_rdy_o;
    drain = (qc_q != '0);

    // Drain is applied to the map before the set is considered.
    map_clr  = drain ? (map_q & ~drn_mask) : map_q;
    drn_hit  = drain && ((map_q & drn_mask) != '0);
    drn_miss = drain && (drn_mask != '0) && !drn_hit;

    set_new = set_v_i && (set_mask != '0)
              && ((map_clr & set_mask) == '0);
    set_dup = set_v_i && ((map_clr & set_mask) != '0);

    new_err = ovf || drn_miss || set_dup
              || (set_v_i && set_ill)
              || (drain && drn_ill);

    map_d = map_clr | (set_v_i ? set_mask : '0);
    cnt_d = cnt_q - {3'b0, drn_hit} + {3'b0, set_new};

    if (new_err) err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else err_d = err_q;

    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = clr_idx_i;
      wp_d = wp_q + 2'd1;
    end
    if (drain) rp_d = rp_q + 2'd1;
    qc_d = qc_q + {2'b0, push} - {2'b0, drain};

    if (flush_i) begin
      map_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
      wp_d  = '0;
      rp_d  = '0;
      qc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      map_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      qc_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      qc_q  <= qc_d;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign map_o   = map_q;
  assign cnt_o   = cnt_q;
  assign err_o   = err_q;
  assign full_o  = (cnt_q == 4'(SLOTS));
  assign empty_o = (cnt_q == 4'd0);

endmodule

// File: tb/tb_slot_map12.sv
// Directed bench for slot_map12: vector table plus
// hand-written multi-cycle sequences.
module tb_slot_map12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        set_v_i;
  logic [3:0]  set_idx_i;
  logic        clr_v_i;
  logic [3:0]  clr_idx_i;
  logic        clr_rdy_o;
  logic [11:0] map_o;
  logic [3:0]  cnt_o;
  logic        full_o;
  logic        empty_o;
  logic        err_o;
  logic        err_clr_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slot_map12 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .set_v_i   (set_v_i),
    .set_idx_i (set_idx_i),
    .clr_v_i   (clr_v_i),
    .clr_idx_i (clr_idx_i),
    .clr_rdy_o (clr_rdy_o),
    .map_o     (map_o),
    .cnt_o     (cnt_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .err_o     (err_o),
    .err_clr_i (err_clr_i)
  );

  typedef struct {
    logic        sv;
    logic [3:0]  si;
    logic        cv;
    logic [3:0]  ci;
    logic        fl;
    logic        ec;
    logic [11:0] map;
    logic [3:0]  cnt;
    logic        err;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [3:0] si,
                       input logic cv, input logic [3:0] ci,
                       input logic fl, input logic ec);
    set_v_i   = sv;
    set_idx_i = si;
    clr_v_i   = cv;
    clr_idx_i = ci;
    flush_i   = fl;
    err_clr_i = ec;
  endtask

  // apply inputs, take one edge, sample 1 time unit later
  task automatic step(input logic sv, input logic [3:0] si,
                      input logic cv, input logic [3:0] ci,
                      input logic fl, input logic ec);
    drive(sv, si, cv, ci, fl, ec);
    @(posedge clk);
    #1;
    drive(0, 4'd15, 0, 4'd15, 0, 0);
  endtask

  task automatic chk_state(input string nm, input logic [11:0] m,
                           input logic [3:0] c, input logic e);
    check({nm, ".map"}, int'(map_o), int'(m));
    check({nm, ".cnt"}, int'(cnt_o), int'(c));
    check({nm, ".err"}, int'(err_o), int'(e));
    check({nm, ".full"}, int'(full_o), int'(c == 4'd12));
    check({nm, ".empty"}, int'(empty_o), int'(c == 4'd0));
  endtask

  vec_t vt [18];

  initial begin
    rst_n = 1'b0;
    drive(0, 4'd15, 0, 4'd15, 0, 0);
    vt[0]  = '{1, 4'd3,  0, 4'd0,  0, 0, 12'h008, 4'd1, 0};
    vt[1]  = '{1, 4'd0,  0, 4'd0,  0, 0, 12'h009, 4'd2, 0};
    vt[2]  = '{1, 4'd11, 0, 4'd0,  0, 0, 12'h809, 4'd3, 0};
    vt[3]  = '{1, 4'd13, 0, 4'd0,  0, 0, 12'h809, 4'd3, 1};
    vt[4]  = '{0, 4'd0,  0, 4'd0,  0, 1, 12'h809, 4'd3, 0};
    vt[5]  = '{1, 4'd2,  0, 4'd0,  0, 0, 12'h80D, 4'd4, 0};
    vt[6]  = '{1, 4'd2,  0, 4'd0,  0, 0, 12'h80D, 4'd4, 1};
    vt[7]  = '{1, 4'd15, 0, 4'd0,  0, 1, 12'h80D, 4'd4, 0};
    vt[8]  = '{1, 4'd15, 0, 4'd0,  0, 0, 12'h80D, 4'd4, 0};
    vt[9]  = '{0, 4'd0,  1, 4'd0,  0, 0, 12'h80D, 4'd4, 0};
    vt[10] = '{0, 4'd0,  0, 4'd0,  0, 0, 12'h80C, 4'd3, 0};
    vt[11] = '{1, 4'd1,  1, 4'd3,  0, 0, 12'h80E, 4'd4, 0};
    vt[12] = '{0, 4'd0,  0, 4'd0,  0, 0, 12'h806, 4'd3, 0};
    vt[13] = '{0, 4'd0,  1, 4'd12, 0, 0, 12'h806, 4'd3, 0};
    vt[14] = '{0, 4'd0,  0, 4'd0,  0, 0, 12'h806, 4'd3, 1};
    vt[15] = '{0, 4'd0,  1, 4'd0,  0, 1, 12'h806, 4'd3, 0};
    vt[16] = '{0, 4'd0,  0, 4'd0,  0, 0, 12'h806, 4'd3, 1};
    vt[17] = '{1, 4'd4,  1, 4'd1,  1, 0, 12'h000, 4'd0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 12'h000, 4'd0, 0);
    check("reset.rdy", int'(clr_rdy_o), 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].sv, vt[i].si, vt[i].cv, vt[i].ci, vt[i].fl, vt[i].ec);
      chk_state($sformatf("vec%0d", i), vt[i].map, vt[i].cnt, vt[i].err);
      check($sformatf("vec%0d.rdy", i), int'(clr_rdy_o), 1);
    end

    // fill all twelve slots
    for (int i = 0; i < 12; i++) step(1, 4'(i), 0, 4'd0, 0, 0);
    chk_state("fill", 12'hFFF, 4'd12, 0);

    // release burst 0..4, queue keeps up with drain
    for (int i = 0; i < 5; i++) begin
      step(0, 4'd0, 1, 4'(i), 0, 0);
      check($sformatf("burst%0d.rdy", i), int'(clr_rdy_o), 1);
    end
    chk_state("burst.mid", 12'hFF0, 4'd8, 0);
    step(0, 4'd0, 0, 4'd0, 0, 0);
    chk_state("burst.end", 12'hFE0, 4'd7, 0);

    // release 5 drains in the same cycle as set 5
    step(0, 4'd0, 1, 4'd5, 0, 0);
    chk_state("coll.q", 12'hFE0, 4'd7, 0);
    step(1, 4'd5, 0, 4'd0, 0, 0);
    chk_state("coll", 12'hFE0, 4'd7, 0);

    // flush with a release pending and set/release in the flush cycle
    step(0, 4'd0, 0, 4'd0, 1, 0);
    for (int i = 4; i < 8; i++) step(1, 4'(i), 0, 4'd0, 0, 0);
    chk_state("fl.pre", 12'h0F0, 4'd4, 0);
    step(0, 4'd0, 1, 4'd4, 0, 0);
    step(1, 4'd7, 1, 4'd5, 1, 0);
    chk_state("flush", 12'h000, 4'd0, 0);
    check("flush.rdy", int'(clr_rdy_o), 1);
    step(1, 4'd4, 0, 4'd0, 0, 0);
    repeat (3) step(0, 4'd0, 0, 4'd0, 0, 0);
    chk_state("fl.post", 12'h010, 4'd1, 0);

    // reset wins over flush and clears error
    step(1, 4'd4, 0, 4'd0, 0, 0);
    check("dup.err", int'(err_o), 1);
    rst_n = 1'b0;
    step(1, 4'd9, 0, 4'd0, 1, 0);
    rst_n = 1'b1;
    chk_state("rst2", 12'h000, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
